seg_display_arbiter: RTL and testbench
======================================

// Module: seg_display_arbiter
// PURPOSE
// - Shares the 8-digit 7-segment display controller among NUM_REQ clients (score, status, debug, ...).
// - Grants ownership round-robin, with a guaranteed minimum dwell time per owner.
// - Registers the owner's 8 digit codes and decimal points, then drives the d0..d7/dp inputs of the display controller.
// - Shows all-blank (code 23) when no client owns the display.
// PARAMETERS
// NUM_REQ             3            number of requesters, range 2..8
// DWELL_CYCLES        100000000    minimum owner tenure in clk cycles (1 s at 100 MHz)
// CNTR_WIDTH          32           dwell counter width; must hold DWELL_CYCLES-1
// SIMULATE            0            1 = use SIMULATE_DWELL_CNT in place of DWELL_CYCLES
// SIMULATE_DWELL_CNT  5            dwell length in cycles when SIMULATE=1
// PORTS
// clk        in   1            system clock
// reset      in   1            synchronous reset, active-low
// req        in   NUM_REQ      level request per client; client holds it high while it wants the display
// digits_in  in   NUM_REQ*40   client i digit codes at [40*i +: 40]; digit k at [5*k +: 5]
// dp_in      in   NUM_REQ*8    client i decimal points at [8*i +: 8]
// grant      out  NUM_REQ      one-hot current owner; all zero when idle
// owner_vld  out  1            1 = display owned
// owner_idx  out  3            index of the current owner; holds the last value while idle
// d_out      out  40           digit codes to the display controller (d7 at [39:35] .. d0 at [4:0])
// dp_out     out  8            decimal points to the display controller
// BEHAVIOUR
// - Reset (reset==0 at a clk edge) forces: grant=0, owner_vld=0, owner_idx=0, d_out={8{5'd23}}, dp_out=0,
//   dwell counter=0, round-robin pointer=0, state=IDLE. This applies mid-operation as well; there is no drain.
// - States:
//   IDLE: no owner.
//   HOLD: owner granted, dwell counter running.
//   OPEN: dwell expired, owner still holds req.
// - IDLE -> HOLD when any req is high.
//   - Pick the first set req at or after the rr pointer, wrapping from NUM_REQ-1 to 0.
//   - grant, owner_idx and owner_vld update on the same edge; the counter clears to 0.
// - HOLD: the counter increments every cycle.
//   - At count == top-1 (top = DWELL_CYCLES or SIMULATE_DWELL_CNT), go to OPEN.
//   - If the owner drops req, release immediately, even before dwell expires.
// - OPEN: the owner keeps the display while no other req is set.
//   - When any other req is set, hand over to the next client after the owner, round-robin (preemption).
//   - Handover goes straight to HOLD for the new owner, with the counter cleared.
// - Release (owner req low, in HOLD or OPEN):
//   - If another req is set, grant it on the next edge and enter HOLD.
//   - Otherwise go to IDLE: grant=0, owner_vld=0.
// - The rr pointer is set to owner_idx+1 (mod NUM_REQ) on every grant, so the previous owner is searched last.
// - Simultaneous events:
//   - Owner release on the same cycle as dwell expiry counts as a release.
//   - Release plus a new req on the same cycle gives a direct handover with no IDLE cycle.
//   - A lone requester is never preempted.
// - Data path: d_out/dp_out are registered copies of the owner's digits_in/dp_in. They track live client changes
//   with 1-cycle latency. On grant change, d_out shows the new owner's digits on the edge after grant changes.
//   In IDLE, d_out is all 5'd23 and dp_out is 0.
// - grant is always one-hot or zero; owner_vld == |grant.
// - Digit codes pass through unmodified; code legality is the display controller's concern.
// STRUCTURE
// - Package seg_disp_pkg:
//   - NUM_DIGITS=8, DIGIT_W=5, BLANK_CODE=5'd23
//   - state encodings IDLE/HOLD/OPEN
//   - function for the 40-bit slice of client i
// - Sub-module seg_rr_picker: purely combinational. Takes req, pointer and an exclude mask; returns found flag
//   and index of the first set req at or after the pointer.
// - Top level: FSM, dwell counter, rr pointer register, output mux/registers.
// TESTING (SIMULATE=1, SIMULATE_DWELL_CNT=5, NUM_REQ=3)
// 1. Reset: hold reset=0 for 2 cycles with req=3'b111 -> grant=0, owner_vld=0, d_out=40'h{8x 23}, dp_out=0.
//    After release, the next edge gives grant=3'b001.
// 2. Rotation: req=3'b111 held -> grant sequence 001,010,100,001. Each owner lasts exactly 5 cycles;
//    d_out follows the owner 1 cycle after grant.
// 3. Lone requester: req=3'b010 for 20 cycles -> grant stays 3'b010 throughout; no preemption after dwell.
// 4. Early release: client 0 owns, drops req at cycle 2 of dwell while req[2]=1 -> next edge grant=3'b100,
//    counter restarts. Client 1 is skipped because req[1]=0.
// 5. Idle fallback: sole owner client 2 drops req -> grant=0, owner_vld=0 next edge;
//    d_out = all 5'd23 one cycle later.
// 6. Reset mid-handover: assert reset=0 on the cycle of dwell expiry with req=3'b011 -> all outputs at reset
//    values; after release, grant=3'b001 because the rr pointer was reset to 0.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared constants, state encoding and client-slice helpers for the
// 7-segment display arbiter.
//   NUM_DIGITS / DIGIT_W : display geometry (8 digits of 5-bit codes)
//   BLANK_CODE           : digit code that lights no segments
//   state_e              : arbiter FSM states
//   client_digits/dp     : extract client i's slice from a packed request bus
package seg_disp_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 5;
  localparam int unsigned DISP_W     = NUM_DIGITS * DIGIT_W;
  localparam int unsigned MAX_REQ    = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned DIG_BUS_W  = MAX_REQ * DISP_W;
  localparam int unsigned DP_BUS_W   = MAX_REQ * NUM_DIGITS;

  localparam logic [DIGIT_W-1:0] BLANK_CODE = 5'd23;
  localparam logic [DISP_W-1:0]  BLANK_DISP = {NUM_DIGITS{BLANK_CODE}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    OPEN = 2'd2
  } state_e;

  // 40-bit digit slice of client idx from a bus padded to MAX_REQ clients
  function automatic logic [DISP_W-1:0] client_digits(
    input logic [DIG_BUS_W-1:0] bus,
    input logic [IDX_W-1:0]     idx
  );
    return bus[DISP_W*idx +: DISP_W];
  endfunction

  // 8-bit decimal-point slice of client idx
  function automatic logic [NUM_DIGITS-1:0] client_dp(
    input logic [DP_BUS_W-1:0] bus,
    input logic [IDX_W-1:0]    idx
  );
    return bus[NUM_DIGITS*idx +: NUM_DIGITS];
  endfunction

endpackage

// File: rtl/seg_rr_picker.sv
// Combinational round-robin search: first set request at or after ptr_i,
// wrapping, ignoring any bit set in excl_i.
//   req_i   : request vector
//   ptr_i   : search start index (must be < NUM_REQ)
//   excl_i  : requests to ignore (the current owner)
//   found_o : a candidate exists
//   idx_o   : index of that candidate
module seg_rr_picker
  import seg_disp_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic [NUM_REQ-1:0] excl_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] rot;

  assign cand = req_i & ~excl_i;
  // Rotate so bit 0 corresponds to ptr_i
  assign rot  = NUM_REQ'({cand, cand} >> ptr_i);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found_o && rot[k]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'((32'(ptr_i) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one 8-digit 7-segment controller among
// NUM_REQ clients, with a minimum dwell per owner and registered data mux.
//   clk, reset (sync, active-low)
//   req        : level request per client
//   digits_in  : client i digits at [40*i +: 40]
//   dp_in      : client i decimal points at [8*i +: 8]
//   grant      : one-hot owner, zero when idle
//   owner_vld  : display owned
//   owner_idx  : current owner index, holds last value while idle
//   d_out      : digit codes to the controller (blank when idle)
//   dp_out     : decimal points to the controller
module seg_display_arbiter
  import seg_disp_pkg::*;
#(
  parameter int unsigned NUM_REQ            = 3,
  parameter int unsigned DWELL_CYCLES       = 100000000,
  parameter int unsigned CNTR_WIDTH         = 32,
  parameter int unsigned SIMULATE           = 0,
  parameter int unsigned SIMULATE_DWELL_CNT = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DISP_W-1:0]  digits_in,
  input  logic [NUM_REQ*NUM_DIGITS-1:0] dp_in,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       owner_vld,
  output logic [IDX_W-1:0]           owner_idx,
  output logic [DISP_W-1:0]          d_out,
  output logic [NUM_DIGITS-1:0]      dp_out
);

  localparam int unsigned TOP = (SIMULATE != 0) ? SIMULATE_DWELL_CNT : DWELL_CYCLES;
  localparam logic [CNTR_WIDTH-1:0] TOP_M1 = CNTR_WIDTH'(TOP - 1);

  state_e                  state_q;
  logic [CNTR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]        rr_q;
  logic [NUM_REQ-1:0]      grant_q;
  logic                    owner_vld_q;
  logic [IDX_W-1:0]        owner_idx_q;
  logic [DISP_W-1:0]       d_q;
  logic [NUM_DIGITS-1:0]   dp_q;

  logic                    pick_found;
  logic [IDX_W-1:0]        pick_idx;
  logic [NUM_REQ-1:0]      pick_oh;
  logic [IDX_W-1:0]        pick_rr;
  logic                    owner_req;
  logic                    take_c, drop_c, open_c;

  // Owner is excluded, so found means "some other client wants the display"
  seg_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i   (req),
    .ptr_i   (rr_q),
    .excl_i  (grant_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign pick_oh   = NUM_REQ'(1'b1) << pick_idx;
  assign pick_rr   = (32'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + IDX_W'(1);
  assign owner_req = |(req & grant_q);
  assign cnt_d     = cnt_q + CNTR_WIDTH'(1);

  // Event decode: take = grant pick, drop = go idle, open = dwell expired alone.
  // Expiry is judged on the last dwell cycle, so a contested owner keeps the
  // display for exactly TOP cycles before handover.
  always_comb begin
    take_c = 1'b0;
    drop_c = 1'b0;
    open_c = 1'b0;
    case (state_q)
      IDLE: take_c = pick_found;
      HOLD: begin
        if (!owner_req) begin
          take_c = pick_found;
          drop_c = !pick_found;
        end else if (cnt_q == TOP_M1) begin
          take_c = pick_found;
          open_c = !pick_found;
        end
      end
      OPEN: begin
        if (!owner_req) begin
          take_c = pick_found;
          drop_c = !pick_found;
        end else begin
          take_c = pick_found;
        end
      end
      default: drop_c = 1'b1;
    endcase
  end

  // Arbiter FSM, dwell counter, rr pointer and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rr_q        <= '0;
      grant_q     <= '0;
      owner_vld_q <= 1'b0;
      owner_idx_q <= '0;
      d_q         <= BLANK_DISP;
      dp_q        <= '0;
    end else begin
      // Data follows the registered owner, so it lags a grant change by one edge
      d_q  <= owner_vld_q ? client_digits(DIG_BUS_W'(digits_in), owner_idx_q) : BLANK_DISP;
      dp_q <= owner_vld_q ? client_dp(DP_BUS_W'(dp_in), owner_idx_q) : '0;

      if (take_c) begin
        state_q     <= HOLD;
        grant_q     <= pick_oh;
        owner_idx_q <= pick_idx;
        owner_vld_q <= 1'b1;
        cnt_q       <= '0;
        rr_q        <= pick_rr;
      end else if (drop_c) begin
        state_q     <= IDLE;
        grant_q     <= '0;
        owner_vld_q <= 1'b0;
        cnt_q       <= '0;
      end else if (open_c) begin
        state_q     <= OPEN;
      end else if (state_q == HOLD) begin
        cnt_q       <= cnt_d;
      end
    end
  end

  assign grant     = grant_q;
  assign owner_vld = owner_vld_q;
  assign owner_idx = owner_idx_q;
  assign d_out     = d_q;
  assign dp_out    = dp_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter (NUM_REQ=3, 5-cycle dwell).
// A tenure-based reference model predicts each edge; a monitor compares.
module tb_seg_display_arbiter;

  localparam int NR   = 3;
  localparam int TOPC = 5;
  localparam int DW   = NR * 40;
  localparam int PW   = NR * 8;
  localparam logic [39:0] BLANK = {8{5'd23}};

  logic          clk;
  logic          reset;
  logic [NR-1:0] req;
  logic [DW-1:0] digits_in;
  logic [PW-1:0] dp_in;
  logic [NR-1:0] grant;
  logic          owner_vld;
  logic [2:0]    owner_idx;
  logic [39:0]   d_out;
  logic [7:0]    dp_out;

  seg_display_arbiter #(
    .NUM_REQ(NR), .DWELL_CYCLES(100), .CNTR_WIDTH(32),
    .SIMULATE(1), .SIMULATE_DWELL_CNT(TOPC)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .digits_in(digits_in), .dp_in(dp_in),
    .grant(grant), .owner_vld(owner_vld), .owner_idx(owner_idx),
    .d_out(d_out), .dp_out(dp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] g;
    logic          v;
    logic [2:0]    idx;
    logic [39:0]   d;
    logic [7:0]    dp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: who owns the display and for how many edges
  int m_owner = -1;
  int m_idx   = 0;
  int m_rr    = 0;
  int m_ten   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int search(input logic [NR-1:0] r, input int start, input int excl);
    for (int k = 0; k < NR; k++) begin
      int p;
      p = (start + k) % NR;
      if (r[p] && p != excl) return p;
    end
    return -1;
  endfunction

  function automatic logic [39:0] dig_of(input int i);
    return digits_in[40*i +: 40];
  endfunction

  // Predict the outputs after the coming edge and queue them
  task automatic push_expected(input logic [NR-1:0] r, input logic rst);
    exp_t e;
    int   nxt;
    int   s;
    if (!rst) begin
      m_owner = -1; m_idx = 0; m_rr = 0; m_ten = 0;
      e.d  = BLANK;
      e.dp = 8'h00;
    end else begin
      e.d  = (m_owner >= 0) ? digits_in[40*m_owner +: 40] : BLANK;
      e.dp = (m_owner >= 0) ? dp_in[8*m_owner +: 8] : 8'h00;
      nxt  = m_owner;
      if (m_owner < 0) begin
        nxt = search(r, m_rr, -1);
      end else if (!r[m_owner]) begin
        nxt = search(r, m_rr, m_owner);
      end else if (m_ten >= TOPC - 1) begin
        s = search(r, m_rr, m_owner);
        if (s >= 0) nxt = s;
      end
      if (nxt != m_owner) begin
        m_ten = 0;
        if (nxt >= 0) begin
          m_idx = nxt;
          m_rr  = (nxt + 1) % NR;
        end
      end else begin
        m_ten++;
      end
      m_owner = nxt;
    end
    e.g   = (m_owner >= 0) ? NR'(1 << m_owner) : '0;
    e.v   = (m_owner >= 0);
    e.idx = 3'(m_idx);
    sb.push_back(e);
  endtask

  // One clock: drive at negedge, predict, then return just after the edge
  task automatic cyc(input logic [NR-1:0] r, input logic rst);
    @(negedge clk);
    req       = r;
    reset     = rst;
    digits_in = DW'({$urandom(), $urandom(), $urandom(), $urandom()});
    dp_in     = PW'($urandom());
    push_expected(r, rst);
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge with a queued prediction is checked
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_grant", 64'(grant), 64'(e.g));
        chk("sb_vld",   64'(owner_vld), 64'(e.v));
        chk("sb_idx",   64'(owner_idx), 64'(e.idx));
        chk("sb_dout",  64'(d_out), 64'(e.d));
        chk("sb_dp",    64'(dp_out), 64'(e.dp));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [NR-1:0] cur;
    logic [NR-1:0] nx;
    logic [NR-1:0] r;
    int            ci;
    reset = 1'b0; req = '0; digits_in = '0; dp_in = '0;

    // Reset held with all requests high
    cyc(3'b111, 1'b0);
    cyc(3'b111, 1'b0);
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_vld",   64'(owner_vld), 64'(0));
    chk("rst_dout",  64'(d_out), 64'(BLANK));
    chk("rst_dp",    64'(dp_out), 64'(0));
    cyc(3'b111, 1'b1);
    chk("rst_first_grant", 64'(grant), 64'(3'b001));

    // Rotation with 5-cycle tenure
    cur = 3'b001; ci = 0;
    for (int h = 0; h < 3; h++) begin
      nx = {cur[NR-2:0], cur[NR-1]};
      for (int j = 1; j <= 5; j++) begin
        cyc(3'b111, 1'b1);
        if (j == 1) chk("rot_dout", 64'(d_out), 64'(dig_of(ci)));
        if (j == 4) chk("rot_keep", 64'(grant), 64'(cur));
        if (j == 5) chk("rot_next", 64'(grant), 64'(nx));
      end
      cur = nx;
      ci  = (ci + 1) % NR;
    end

    // Lone requester never preempted
    cyc(3'b010, 1'b1);
    chk("lone_take", 64'(grant), 64'(3'b010));
    for (int i = 0; i < 20; i++) begin
      cyc(3'b010, 1'b1);
      chk("lone_keep", 64'(grant), 64'(3'b010));
    end

    // Early release skips idle client 1
    cyc(3'b001, 1'b1);
    chk("early_own0", 64'(grant), 64'(3'b001));
    cyc(3'b101, 1'b1);
    cyc(3'b101, 1'b1);
    chk("early_still0", 64'(grant), 64'(3'b001));
    cyc(3'b100, 1'b1);
    chk("early_to2", 64'(grant), 64'(3'b100));

    // Idle fallback
    cyc(3'b000, 1'b1);
    chk("idle_grant", 64'(grant), 64'(0));
    chk("idle_vld",   64'(owner_vld), 64'(0));
    chk("idle_dlag",  64'(d_out), 64'(dig_of(2)));
    cyc(3'b000, 1'b1);
    chk("idle_blank", 64'(d_out), 64'(BLANK));
    chk("idle_dp",    64'(dp_out), 64'(0));

    // Reset exactly on the dwell-expiry edge
    cyc(3'b011, 1'b1);
    chk("mid_own0", 64'(grant), 64'(3'b001));
    for (int i = 0; i < 4; i++) cyc(3'b011, 1'b1);
    chk("mid_pre", 64'(grant), 64'(3'b001));
    cyc(3'b011, 1'b0);
    chk("mid_rst_grant", 64'(grant), 64'(0));
    chk("mid_rst_idx",   64'(owner_idx), 64'(0));
    chk("mid_rst_dout",  64'(d_out), 64'(BLANK));
    cyc(3'b011, 1'b1);
    chk("mid_regrant", 64'(grant), 64'(3'b001));

    // Random traffic with occasional reset
    r = 3'b111;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = NR'($urandom());
      cyc(r, ($urandom_range(0, 49) != 0));
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    chk("sb_drain", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
